// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file.
package rf_pkg;

  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  // Ceiling log2, used for address widths.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-read-port selection: zero register, W1 bypass, W0 bypass, then array word.
module rf_bypass_mux #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          busy,
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] mem_word,
  input  logic          wv0,
  input  logic [AW-1:0] waddr0,
  input  logic [DW-1:0] wdata0,
  input  logic          wv1,
  input  logic [AW-1:0] waddr1,
  input  logic [DW-1:0] wdata1,
  output logic [DW-1:0] rdata
);

  // First match wins; wv0/wv1 are already qualified as effective writes.
  always_comb begin
    rdata = '0;
    if (busy)                                rdata = '0;
    else if ((ZERO_REG != 0) && raddr == '0) rdata = '0;
    else if (wv1 && waddr1 == raddr)         rdata = wdata1;
    else if (wv0 && waddr0 == raddr)         rdata = wdata0;
    else                                     rdata = mem_word;
  end

endmodule

// File: rtl/rf_multiport.sv
// NUM_RD-read / 2-write register file with same-cycle bypass and a
// post-reset clear sequencer that zeroes every entry.
module rf_multiport
  import rf_pkg::*;
#(
  parameter  int DW       = RF_DW,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] raddr,
  output logic [NUM_RD*DW-1:0] rdata,
  input  logic                 we0,
  input  logic [AW-1:0]        waddr0,
  input  logic [DW-1:0]        wdata0,
  input  logic                 we1,
  input  logic [AW-1:0]        waddr1,
  input  logic [DW-1:0]        wdata1,
  output logic                 busy,
  output logic                 wr_coll
);

  logic [DW-1:0] mem [DEPTH];
  rf_state_e     state_q, state_d;
  logic [AW-1:0] idx;
  logic          wv0, wv1, coll;

  assign busy = (state_q == RF_CLEAR);

  // A write port only counts in RUN and never targets a hardwired zero entry.
  assign wv0  = we0 && !busy && !((ZERO_REG != 0) && waddr0 == '0);
  assign wv1  = we1 && !busy && !((ZERO_REG != 0) && waddr1 == '0);
  assign coll = wv0 && wv1 && (waddr0 == waddr1);

  // State register; reset always restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RF_CLEAR;
    else     state_q <= state_d;
  end

  // Leave CLEAR once the last entry is being zeroed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RF_CLEAR: if (idx == AW'(DEPTH-1)) state_d = RF_RUN;
      RF_RUN:   state_d = RF_RUN;
      default:  state_d = RF_CLEAR;
    endcase
  end

  // Clear index walks 0..DEPTH-1 while clearing.
  always_ff @(posedge clk) begin
    if (rst)                     idx <= '0;
    else if (state_q == RF_CLEAR) idx <= idx + AW'(1);
  end

  // Collision flag reports the previous cycle's W0/W1 same-address write.
  always_ff @(posedge clk) begin
    if (rst) wr_coll <= 1'b0;
    else     wr_coll <= coll;
  end

  // Array update: zero one entry per cycle in CLEAR, else apply writes (W1 wins).
  // Contents are left alone in the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == RF_CLEAR) begin
        mem[idx] <= '0;
      end else begin
        if (wv0 && !coll) mem[waddr0] <= wdata0;
        if (wv1)          mem[waddr1] <= wdata1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_bypass_mux #(
      .DW       (DW),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_mux (
      .busy     (busy),
      .raddr    (raddr[k*AW +: AW]),
      .mem_word (mem[raddr[k*AW +: AW]]),
      .wv0      (wv0),
      .waddr0   (waddr0),
      .wdata0   (wdata0),
      .wv1      (wv1),
      .waddr1   (waddr1),
      .wdata1   (wdata1),
      .rdata    (rdata[k*DW +: DW])
    );
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport: three instances (default, ZERO_REG=0,
// wide 4-port) with a read-expectation scoreboard.
module tb_rf_multiport;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // shared stimulus for instances A (ZERO_REG=1) and B (ZERO_REG=0)
  logic [9:0]  raddr  = '0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [4:0]  waddr0 = '0, waddr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [63:0] rdata_a, rdata_b;
  logic        busy_a, busy_b, coll_a, coll_b;

  // instance C: DW=64, DEPTH=64, NUM_RD=4
  logic [23:0]  raddr_c = '0;
  logic         we0_c = 1'b0, we1_c = 1'b0;
  logic [5:0]   waddr0_c = '0, waddr1_c = '0;
  logic [63:0]  wdata0_c = '0, wdata1_c = '0;
  logic [255:0] rdata_c;
  logic         busy_c, coll_c;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          dut;
    int          port;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  rf_multiport #(.DW(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) u_a (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_a),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .busy(busy_a), .wr_coll(coll_a));

  rf_multiport #(.DW(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .busy(busy_b), .wr_coll(coll_b));

  rf_multiport #(.DW(64), .DEPTH(64), .NUM_RD(4), .ZERO_REG(1)) u_c (
    .clk(clk), .rst(rst), .raddr(raddr_c), .rdata(rdata_c),
    .we0(we0_c), .waddr0(waddr0_c), .wdata0(wdata0_c),
    .we1(we1_c), .waddr1(waddr1_c), .wdata1(wdata1_c),
    .busy(busy_c), .wr_coll(coll_c));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rd(input int dut, input int port);
    case (dut)
      0:       return {32'b0, rdata_a[port*32 +: 32]};
      1:       return {32'b0, rdata_b[port*32 +: 32]};
      default: return rdata_c[port*64 +: 64];
    endcase
  endfunction

  task automatic expect_rd(input string tag, input int dut, input int port, input logic [63:0] exp);
    exp_t e;
    e.tag = tag; e.dut = dut; e.port = port; e.exp = exp;
    sb.push_back(e);
  endtask

  // let combinational reads settle, then compare every queued expectation
  task automatic sample();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, rd(e.dut, e.port), e.exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ra(input int p0, input int p1);
    raddr = {5'(p1), 5'(p0)};
  endtask

  initial begin
    // ---- 1: reset, clear length, writes ignored while busy
    @(negedge clk);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
    ra(5, 0);
    for (int k = 0; k < 32; k++) begin
      expect_rd("clr_rd0", 0, 0, 64'h0);
      expect_rd("clr_rd1", 0, 1, 64'h0);
      sample();
      check("clr_busy", {63'b0, busy_a}, 64'h1);
      check("clr_coll", {63'b0, coll_a}, 64'h0);
      nxt();
    end
    #1;
    check("clr_done", {63'b0, busy_a}, 64'h0);
    we0 = 1'b0;

    // ---- 2: W0 bypass then read from array; r5 untouched by busy write
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1234_5678;
    ra(3, 5);
    expect_rd("w0_byp", 0, 0, 64'h1234_5678);
    expect_rd("r5_zero", 0, 1, 64'h0);
    sample();
    nxt();
    we0 = 1'b0;
    expect_rd("w0_mem", 0, 0, 64'h1234_5678);
    sample();
    nxt();

    // ---- 3: same-address collision, W1 wins
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h0000_0011;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h0000_0022;
    ra(7, 7);
    expect_rd("coll_byp0", 0, 0, 64'h22);
    expect_rd("coll_byp1", 0, 1, 64'h22);
    sample();
    check("coll_pre", {63'b0, coll_a}, 64'h0);
    nxt();
    we0 = 1'b0; we1 = 1'b0;
    expect_rd("coll_mem0", 0, 0, 64'h22);
    expect_rd("coll_mem1", 0, 1, 64'h22);
    sample();
    check("coll_pulse", {63'b0, coll_a}, 64'h1);
    nxt();
    #1;
    check("coll_end", {63'b0, coll_a}, 64'h0);

    // distinct addresses on both ports: no collision, both land
    we0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h0000_AAAA;
    we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h0000_BBBB;
    ra(1, 2);
    expect_rd("dual_byp0", 0, 0, 64'hAAAA);
    expect_rd("dual_byp1", 0, 1, 64'hBBBB);
    sample();
    nxt();
    we0 = 1'b0; we1 = 1'b0;
    expect_rd("dual_mem0", 0, 0, 64'hAAAA);
    expect_rd("dual_mem1", 0, 1, 64'hBBBB);
    sample();
    check("dual_nocoll", {63'b0, coll_a}, 64'h0);
    nxt();

    // ---- 4: writes to r0 with and without the hardwired zero
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
    ra(0, 0);
    expect_rd("z_byp_a", 0, 0, 64'h0);
    expect_rd("z_byp_b", 1, 0, 64'hFFFF_FFFF);
    sample();
    nxt();
    we1 = 1'b0;
    expect_rd("z_mem_a", 0, 0, 64'h0);
    expect_rd("z_mem_b", 1, 0, 64'hFFFF_FFFF);
    sample();
    check("z_coll_a", {63'b0, coll_a}, 64'h0);
    nxt();

    // both ports at r0: collision only when r0 is a real register
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h0000_1111;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'h0000_2222;
    expect_rd("z2_byp_a", 0, 0, 64'h0);
    expect_rd("z2_byp_b", 1, 0, 64'h2222);
    sample();
    nxt();
    we0 = 1'b0; we1 = 1'b0;
    expect_rd("z2_mem_a", 0, 0, 64'h0);
    expect_rd("z2_mem_b", 1, 0, 64'h2222);
    sample();
    check("z2_coll_a", {63'b0, coll_a}, 64'h0);
    check("z2_coll_b", {63'b0, coll_b}, 64'h1);
    nxt();

    // ---- 5: reset restarted mid-clear
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("rc_busy_a", {63'b0, busy_a}, 64'h1);
      nxt();
    end
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      #1;
      check("rc_busy_b", {63'b0, busy_a}, 64'h1);
      nxt();
    end
    #1;
    check("rc_done", {63'b0, busy_a}, 64'h0);
    for (int i = 0; i < 32; i++) begin
      ra(i, 31 - i);
      expect_rd("clr_all0", 0, 0, 64'h0);
      expect_rd("clr_all1", 0, 1, 64'h0);
      expect_rd("clr_all_b", 1, 0, 64'h0);
      sample();
      nxt();
    end

    // ---- 6: wide 4-port instance
    for (int n = 0; n < 200 && busy_c; n++) nxt();
    #1;
    check("c_ready", {63'b0, busy_c}, 64'h0);
    we0_c = 1'b1; waddr0_c = 6'd63; wdata0_c = 64'h0123_4567_89AB_CDEF;
    raddr_c = {6'd62, 6'd62, 6'd62, 6'd63};
    expect_rd("c_byp", 2, 0, 64'h0123_4567_89AB_CDEF);
    expect_rd("c_byp_62", 2, 1, 64'h0);
    sample();
    nxt();
    we0_c = 1'b0;
    raddr_c = {6'd63, 6'd63, 6'd63, 6'd63};
    for (int p = 0; p < 4; p++) expect_rd("c_r63", 2, p, 64'h0123_4567_89AB_CDEF);
    sample();
    nxt();
    raddr_c = {6'd62, 6'd63, 6'd62, 6'd62};
    expect_rd("c_r62", 2, 0, 64'h0);
    expect_rd("c_mix", 2, 2, 64'h0123_4567_89AB_CDEF);
    expect_rd("c_r62_p3", 2, 3, 64'h0);
    sample();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
